// File: rtl/clct_sort_sequencer.sv
// clct_sort_sequencer: two-pass sweep of MXBANK banks through one shared best-1-of-32 sorter
// Finds the chamber-wide best pattern in pass 1, then re-sweeps with a key window blanked
// around it to find the second best. Ports:
//   clock, reset_n           clock and asynchronous active-low reset
//   start / busy / done      request, in-progress flag, one-clock completion pulse
//   sort_bank                bank index driven to the sorter input mux
//   blank_en/lo/hi           pass-2 blank window (inclusive chamber keys) for the input mux
//   srt_pat/key/carry        sorter result, SORT_LAT clocks after sort_bank
//   best1_*, best2_*         results, updated on the done edge and held until the next done
module clct_sort_sequencer #(
    parameter int MXPATB     = 7,
    parameter int MXPATC     = 12,
    parameter int MXBANK     = 7,
    parameter int MXKEYB     = 5,
    parameter int MXKEYBT    = 8,
    parameter int SORT_LAT   = 1,
    parameter int BLANK_SPAN = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic [2:0]         sort_bank,
    output logic               blank_en,
    output logic [MXKEYBT-1:0] blank_lo,
    output logic [MXKEYBT-1:0] blank_hi,
    input  logic [MXPATB-1:0]  srt_pat,
    input  logic [MXKEYB-1:0]  srt_key,
    input  logic [MXPATC-1:0]  srt_carry,
    output logic               done,
    output logic               best1_vld,
    output logic [MXPATB-1:0]  best1_pat,
    output logic [MXKEYBT-1:0] best1_key,
    output logic [MXPATC-1:0]  best1_carry,
    output logic               best2_vld,
    output logic [MXPATB-1:0]  best2_pat,
    output logic [MXKEYBT-1:0] best2_key,
    output logic [MXPATC-1:0]  best2_carry
);
    localparam int KEY_MAX = 32 * MXBANK - 1;
    localparam int CNTW    = $clog2(SORT_LAT + 1);

    typedef enum logic [2:0] {IDLE, P1_ISSUE, P1_DRAIN, BLANK, P2_ISSUE, P2_DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic                          busy_q, busy_d, done_q, done_d;
    logic [2:0]                    sort_bank_q, sort_bank_d;
    logic [CNTW-1:0]               cnt_q, cnt_d;
    logic [SORT_LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [SORT_LAT-1:0][2:0]      tag_bank_q, tag_bank_d;
    logic [MXPATB-1:0]             run_pat_q, run_pat_d, p1_pat_q, p1_pat_d;
    logic [MXKEYBT-1:0]            run_key_q, run_key_d, p1_key_q, p1_key_d;
    logic [MXPATC-1:0]             run_carry_q, run_carry_d, p1_carry_q, p1_carry_d;
    logic                          blank_en_q, blank_en_d;
    logic [MXKEYBT-1:0]            blank_lo_q, blank_lo_d, blank_hi_q, blank_hi_d;
    logic                          best1_vld_q, best1_vld_d, best2_vld_q, best2_vld_d;
    logic [MXPATB-1:0]             best1_pat_q, best1_pat_d, best2_pat_q, best2_pat_d;
    logic [MXKEYBT-1:0]            best1_key_q, best1_key_d, best2_key_q, best2_key_d;
    logic [MXPATC-1:0]             best1_carry_q, best1_carry_d, best2_carry_q, best2_carry_d;

    logic accept, issuing, draining, bank_last, drain_last, cap, run_vld, p1_vld;
    logic [MXKEYBT-1:0] win_lo, win_hi;

    // done_q blocks the done cycle itself from restarting the sweep
    assign accept     = state_q == IDLE && start && !done_q;
    assign issuing    = state_q == P1_ISSUE || state_q == P2_ISSUE;
    assign draining   = state_q == P1_DRAIN || state_q == P2_DRAIN;
    assign bank_last  = sort_bank_q == 3'(MXBANK - 1);
    assign drain_last = cnt_q == CNTW'(SORT_LAT - 1);
    assign run_vld    = run_pat_q[MXPATB-1:1] != '0;
    assign p1_vld     = p1_pat_q[MXPATB-1:1] != '0;
    // strict compare: equal values arriving later (higher key) never displace the stored best
    assign cap        = tag_vld_q[SORT_LAT-1] && srt_pat[MXPATB-1:1] > run_pat_q[MXPATB-1:1];
    assign win_lo     = (int'(run_key_q) < BLANK_SPAN) ? '0 : MXKEYBT'(int'(run_key_q) - BLANK_SPAN);
    assign win_hi     = (int'(run_key_q) + BLANK_SPAN > KEY_MAX) ? MXKEYBT'(KEY_MAX)
                                                                 : MXKEYBT'(int'(run_key_q) + BLANK_SPAN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sort_bank_q   <= '0;
            cnt_q         <= '0;
            tag_vld_q     <= '0;
            tag_bank_q    <= '0;
            run_pat_q     <= '0;
            run_key_q     <= '0;
            run_carry_q   <= '0;
            p1_pat_q      <= '0;
            p1_key_q      <= '0;
            p1_carry_q    <= '0;
            blank_en_q    <= 1'b0;
            blank_lo_q    <= '0;
            blank_hi_q    <= '0;
            best1_vld_q   <= 1'b0;
            best1_pat_q   <= '0;
            best1_key_q   <= '0;
            best1_carry_q <= '0;
            best2_vld_q   <= 1'b0;
            best2_pat_q   <= '0;
            best2_key_q   <= '0;
            best2_carry_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sort_bank_q   <= sort_bank_d;
            cnt_q         <= cnt_d;
            tag_vld_q     <= tag_vld_d;
            tag_bank_q    <= tag_bank_d;
            run_pat_q     <= run_pat_d;
            run_key_q     <= run_key_d;
            run_carry_q   <= run_carry_d;
            p1_pat_q      <= p1_pat_d;
            p1_key_q      <= p1_key_d;
            p1_carry_q    <= p1_carry_d;
            blank_en_q    <= blank_en_d;
            blank_lo_q    <= blank_lo_d;
            blank_hi_q    <= blank_hi_d;
            best1_vld_q   <= best1_vld_d;
            best1_pat_q   <= best1_pat_d;
            best1_key_q   <= best1_key_d;
            best1_carry_q <= best1_carry_d;
            best2_vld_q   <= best2_vld_d;
            best2_pat_q   <= best2_pat_d;
            best2_key_q   <= best2_key_d;
            best2_carry_q <= best2_carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = accept ? P1_ISSUE : IDLE;
            P1_ISSUE: state_d = bank_last ? P1_DRAIN : P1_ISSUE;
            P1_DRAIN: state_d = drain_last ? BLANK : P1_DRAIN;
            BLANK:    state_d = P2_ISSUE;
            P2_ISSUE: state_d = bank_last ? P2_DRAIN : P2_ISSUE;
            P2_DRAIN: state_d = drain_last ? DONE : P2_DRAIN;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d        = accept ? 1'b1 : (state_q == DONE ? 1'b0 : busy_q);
        done_d        = state_q == DONE;
        sort_bank_d   = (accept || state_q == BLANK || state_q == DONE) ? '0
                      : (issuing && !bank_last) ? sort_bank_q + 3'd1 : sort_bank_q;
        cnt_d         = (draining && !drain_last) ? cnt_q + CNTW'(1) : '0;
        // bank-index tags travel alongside the sorter pipeline so each result knows its bank
        tag_vld_d     = tag_vld_q;
        tag_bank_d    = tag_bank_q;
        tag_vld_d[0]  = issuing;
        tag_bank_d[0] = sort_bank_q;
        for (int i = 1; i < SORT_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_bank_d[i] = tag_bank_q[i-1];
        end
        run_pat_d     = (accept || state_q == BLANK) ? '0 : cap ? srt_pat : run_pat_q;
        run_key_d     = (accept || state_q == BLANK) ? '0
                      : cap ? MXKEYBT'({tag_bank_q[SORT_LAT-1], srt_key}) : run_key_q;
        run_carry_d   = (accept || state_q == BLANK) ? '0 : cap ? srt_carry : run_carry_q;
        p1_pat_d      = state_q == BLANK ? run_pat_q : p1_pat_q;
        p1_key_d      = state_q == BLANK ? run_key_q : p1_key_q;
        p1_carry_d    = state_q == BLANK ? run_carry_q : p1_carry_q;
        blank_en_d    = state_q == BLANK ? run_vld : (state_q == DONE ? 1'b0 : blank_en_q);
        blank_lo_d    = state_q == BLANK ? (run_vld ? win_lo : '0) : (state_q == DONE ? '0 : blank_lo_q);
        blank_hi_d    = state_q == BLANK ? (run_vld ? win_hi : '0) : (state_q == DONE ? '0 : blank_hi_q);
        best1_vld_d   = state_q == DONE ? p1_vld : best1_vld_q;
        best1_pat_d   = state_q == DONE ? p1_pat_q : best1_pat_q;
        best1_key_d   = state_q == DONE ? p1_key_q : best1_key_q;
        best1_carry_d = state_q == DONE ? p1_carry_q : best1_carry_q;
        // a second best is meaningless without a first
        best2_vld_d   = state_q == DONE ? p1_vld && run_vld : best2_vld_q;
        best2_pat_d   = state_q == DONE ? (p1_vld ? run_pat_q : '0) : best2_pat_q;
        best2_key_d   = state_q == DONE ? (p1_vld ? run_key_q : '0) : best2_key_q;
        best2_carry_d = state_q == DONE ? (p1_vld ? run_carry_q : '0) : best2_carry_q;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sort_bank   = sort_bank_q;
    assign blank_en    = blank_en_q;
    assign blank_lo    = blank_lo_q;
    assign blank_hi    = blank_hi_q;
    assign best1_vld   = best1_vld_q;
    assign best1_pat   = best1_pat_q;
    assign best1_key   = best1_key_q;
    assign best1_carry = best1_carry_q;
    assign best2_vld   = best2_vld_q;
    assign best2_pat   = best2_pat_q;
    assign best2_key   = best2_key_q;
    assign best2_carry = best2_carry_q;
endmodule

// File: tb/tb_clct_sort_sequencer.sv
// tb_clct_sort_sequencer: directed vectors for the two-pass CLCT sort sequencer
module tb_clct_sort_sequencer;
    logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic        busy, blank_en, done, best1_vld, best2_vld;
    logic [2:0]  sort_bank;
    logic [7:0]  blank_lo, blank_hi, best1_key, best2_key;
    logic [6:0]  srt_pat = '0, best1_pat, best2_pat;
    logic [4:0]  srt_key = '0;
    logic [11:0] srt_carry = '0, best1_carry, best2_carry;
    logic [6:0]  mem [224];
    int          errors = 0, checks = 0;

    typedef struct {
        int         ka, kb, kc;
        logic [6:0] pa, pb, pc;
        logic       b1v;
        logic [6:0] b1p;
        logic [7:0] b1k;
        logic       b2v;
        logic [6:0] b2p;
        logic [7:0] b2k;
        logic       ben;
        logic [7:0] blo, bhi;
    } vec_t;
    vec_t tv [7];

    clct_sort_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .sort_bank(sort_bank),
        .blank_en(blank_en), .blank_lo(blank_lo), .blank_hi(blank_hi),
        .srt_pat(srt_pat), .srt_key(srt_key), .srt_carry(srt_carry), .done(done),
        .best1_vld(best1_vld), .best1_pat(best1_pat), .best1_key(best1_key), .best1_carry(best1_carry),
        .best2_vld(best2_vld), .best2_pat(best2_pat), .best2_key(best2_key), .best2_carry(best2_carry)
    );

    always #5 clock = ~clock;

    // one-clock sorter: best of the selected bank with blanked keys removed, lowest key on ties
    always @(posedge clock) begin
        logic [6:0] bp;
        logic [4:0] bk;
        int         key;
        bp = '0;
        bk = '0;
        for (int k = 0; k < 32; k++) begin
            key = int'(sort_bank) * 32 + k;
            if (!(blank_en && key >= int'(blank_lo) && key <= int'(blank_hi)) && mem[key][6:1] > bp[6:1]) begin
                bp = mem[key];
                bk = 5'(k);
            end
        end
        srt_pat   <= bp;
        srt_key   <= bk;
        srt_carry <= (bp[6:1] == '0) ? 12'h0 : {4'hA, sort_bank, bk};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        foreach (mem[k]) mem[k] = '0;
        mem[v.ka] = v.pa;
        mem[v.kb] = v.pb;
        mem[v.kc] = v.pc;
    endtask

    initial begin
        int         lat;
        logic       ben;
        logic [7:0] blo, bhi;
        tv[0] = '{113, 0, 0, 7'h3C, 7'h00, 7'h00, 1'b1, 7'h3C, 8'd113, 1'b0, 7'h00, 8'd0,   1'b1, 8'd103, 8'd123};
        tv[1] = '{40, 170, 0, 7'h3C, 7'h3D, 7'h00, 1'b1, 7'h3C, 8'd40,  1'b1, 7'h3D, 8'd170, 1'b1, 8'd30,  8'd50};
        tv[2] = '{2, 9, 40,   7'h50, 7'h40, 7'h20, 1'b1, 7'h50, 8'd2,   1'b1, 7'h20, 8'd40,  1'b1, 8'd0,   8'd12};
        tv[3] = '{0, 0, 0,    7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 8'd0,   1'b0, 7'h00, 8'd0,   1'b0, 8'd0,   8'd0};
        tv[4] = '{220, 210, 5, 7'h7F, 7'h10, 7'h02, 1'b1, 7'h7F, 8'd220, 1'b1, 7'h02, 8'd5,  1'b1, 8'd210, 8'd223};
        tv[5] = '{50, 0, 0,   7'h01, 7'h00, 7'h00, 1'b0, 7'h00, 8'd0,   1'b0, 7'h00, 8'd0,   1'b0, 8'd0,   8'd0};
        tv[6] = '{64, 65, 100, 7'h22, 7'h23, 7'h22, 1'b1, 7'h22, 8'd64, 1'b1, 7'h22, 8'd100, 1'b1, 8'd54,  8'd74};
        foreach (mem[k]) mem[k] = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bank", 32'(sort_bank), 0);
        chk("rst_blank_en", 32'(blank_en), 0);
        chk("rst_best1_vld", 32'(best1_vld), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            load(tv[i]);
            @(negedge clock) start = 1'b1;
            @(negedge clock) start = 1'b0;
            lat = 0;
            ben = 1'b0;
            blo = '0;
            bhi = '0;
            chk($sformatf("v%0d_busy", i), 32'(busy), 1);
            while (!done && lat < 40) begin
                @(negedge clock);
                lat++;
                if (lat == 10) begin
                    ben = blank_en;
                    blo = blank_lo;
                    bhi = blank_hi;
                end
            end
            chk($sformatf("v%0d_latency", i), lat, 18);
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 0);
            chk($sformatf("v%0d_blank_en", i), 32'(ben), 32'(tv[i].ben));
            chk($sformatf("v%0d_blank_lo", i), 32'(blo), 32'(tv[i].blo));
            chk($sformatf("v%0d_blank_hi", i), 32'(bhi), 32'(tv[i].bhi));
            chk($sformatf("v%0d_best1_vld", i), 32'(best1_vld), 32'(tv[i].b1v));
            chk($sformatf("v%0d_best1_pat", i), 32'(best1_pat), 32'(tv[i].b1p));
            chk($sformatf("v%0d_best1_key", i), 32'(best1_key), 32'(tv[i].b1k));
            chk($sformatf("v%0d_best1_carry", i), 32'(best1_carry), tv[i].b1v ? 32'({4'hA, tv[i].b1k}) : 0);
            chk($sformatf("v%0d_best2_vld", i), 32'(best2_vld), 32'(tv[i].b2v));
            chk($sformatf("v%0d_best2_pat", i), 32'(best2_pat), 32'(tv[i].b2p));
            chk($sformatf("v%0d_best2_key", i), 32'(best2_key), 32'(tv[i].b2k));
            chk($sformatf("v%0d_best2_carry", i), 32'(best2_carry), tv[i].b2v ? 32'({4'hA, tv[i].b2k}) : 0);
        end
        foreach (mem[k]) mem[k] = '0;
        repeat (3) @(negedge clock);
        chk("hold_best1_key", 32'(best1_key), 32'(tv[6].b1k));
        chk("hold_best2_key", 32'(best2_key), 32'(tv[6].b2k));
        chk("hold_blank_en", 32'(blank_en), 0);
        chk("done_single_pulse", 32'(done), 0);
        // start re-pulsed mid-sweep and in the done cycle must be ignored
        load(tv[0]);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
            start = (lat == 5);
        end
        chk("repulse_latency", lat, 18);
        start = 1'b1;
        @(negedge clock);
        chk("done_cycle_start_busy", 32'(busy), 0);
        chk("done_cycle_start_done", 32'(done), 0);
        @(negedge clock) start = 1'b0;
        chk("restart_accepted", 32'(busy), 1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk("restart_latency", lat, 18);
        chk("restart_best1_key", 32'(best1_key), 113);
        // asynchronous reset in the middle of pass 2
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (11) @(negedge clock);
        chk("p2_bank_nonzero", 32'(sort_bank != 0), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_bank", 32'(sort_bank), 0);
        chk("midrst_blank_en", 32'(blank_en), 0);
        chk("midrst_best1_vld", 32'(best1_vld), 0);
        chk("midrst_best1_key", 32'(best1_key), 0);
        @(negedge clock) reset_n = 1'b1;
        load(tv[1]);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk("post_rst_latency", lat, 18);
        chk("post_rst_best1_key", 32'(best1_key), 40);
        chk("post_rst_best2_key", 32'(best2_key), 170);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
